// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns ASCII bytes from the UART RX FIFO into one-cycle
// command pulses for the shot-clock controller and answers each command with
// a one-byte ACK ('K') or NAK ('?') through the UART TX FIFO.
//
// state  | meaning
// IDLE   | waiting for a command byte
// GET_D1 | 'l' seen, waiting for the tens digit
// GET_D2 | tens digit held, waiting for the ones digit
// REPLY  | reply byte latched, waiting for room in the TX FIFO
module uart_cmd_decoder #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TIMEOUT_MS = 2000,
  parameter int unsigned MAX_LOAD   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic [7:0] w_data,
  output logic       wr_uart,
  output logic       cmd_reset,
  output logic       cmd_stop,
  output logic       cmd_play,
  output logic       cmd_load,
  output logic [3:0] load_tens,
  output logic [3:0] load_ones,
  output logic       err
);

  localparam int unsigned TO_CYCLES = (CLK_HZ / 1000) * TIMEOUT_MS;
  localparam int unsigned CNT_W     = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYCLES - 1);
  localparam logic [6:0] MAX_VAL = 7'(MAX_LOAD);

  localparam logic [7:0] CH_R   = 8'h52;
  localparam logic [7:0] CH_S   = 8'h53;
  localparam logic [7:0] CH_P   = 8'h50;
  localparam logic [7:0] CH_L   = 8'h4C;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_ACK = 8'h4B;
  localparam logic [7:0] CH_NAK = 8'h3F;

  // pulse vector order: {reset, stop, play, load, err}
  localparam logic [4:0] P_RESET = 5'b10000;
  localparam logic [4:0] P_STOP  = 5'b01000;
  localparam logic [4:0] P_PLAY  = 5'b00100;
  localparam logic [4:0] P_LOAD  = 5'b00010;
  localparam logic [4:0] P_ERR   = 5'b00001;

  typedef enum logic [1:0] {IDLE, GET_D1, GET_D2, REPLY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       d1, d1_nxt;
  logic [7:0]       reply, reply_nxt;
  logic [4:0]       pulse, pulse_nxt;
  logic [3:0]       tens_nxt, ones_nxt;

  logic [7:0] ub;
  logic       is_digit;
  logic [3:0] digit;
  logic [6:0] value;

  // Upper-cased byte folds 'r'/'R' etc. together; only commands are folded.
  assign ub       = r_data & 8'hDF;
  assign is_digit = (r_data >= 8'h30) && (r_data <= 8'h39);
  assign digit    = r_data[3:0];
  assign value    = ({3'b000, d1} * 7'd10) + {3'b000, digit};

  // Pop and push never share a state, so RX and TX never contend.
  assign rd_uart = !rst && !rx_empty && (state != REPLY);
  assign wr_uart = (state == REPLY) && !tx_full;
  assign w_data  = reply;
  assign {cmd_reset, cmd_stop, cmd_play, cmd_load, err} = pulse;

  // Next-state, reply and pulse decode for the consumed byte or timeout.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    d1_nxt    = d1;
    reply_nxt = reply;
    pulse_nxt = 5'b00000;
    tens_nxt  = load_tens;
    ones_nxt  = load_ones;
    case (state)
      IDLE: begin
        if (rd_uart) begin
          if (ub == CH_R) begin
            pulse_nxt = P_RESET; reply_nxt = CH_ACK; state_nxt = REPLY;
          end else if (ub == CH_S) begin
            pulse_nxt = P_STOP;  reply_nxt = CH_ACK; state_nxt = REPLY;
          end else if (ub == CH_P) begin
            pulse_nxt = P_PLAY;  reply_nxt = CH_ACK; state_nxt = REPLY;
          end else if (ub == CH_L) begin
            cnt_nxt   = '0;
            state_nxt = GET_D1;
          end else if ((r_data == CH_CR) || (r_data == CH_LF) || (r_data == CH_SP)) begin
            state_nxt = IDLE;
          end else begin
            pulse_nxt = P_ERR;   reply_nxt = CH_NAK; state_nxt = REPLY;
          end
        end
      end
      GET_D1, GET_D2: begin
        if (rd_uart) begin
          cnt_nxt = '0;
          if (!is_digit) begin
            pulse_nxt = P_ERR; reply_nxt = CH_NAK; state_nxt = REPLY;
          end else if (state == GET_D1) begin
            d1_nxt    = digit;
            state_nxt = GET_D2;
          end else if ((value != 7'd0) && (value <= MAX_VAL)) begin
            tens_nxt  = d1;
            ones_nxt  = digit;
            pulse_nxt = P_LOAD; reply_nxt = CH_ACK; state_nxt = REPLY;
          end else begin
            pulse_nxt = P_ERR; reply_nxt = CH_NAK; state_nxt = REPLY;
          end
        end else if (cnt == CNT_LAST) begin
          pulse_nxt = P_ERR; reply_nxt = CH_NAK; state_nxt = REPLY;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      REPLY: begin
        if (!tx_full) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, timeout counter, held digit, reply byte, pulses and load value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      d1        <= '0;
      reply     <= '0;
      pulse     <= '0;
      load_tens <= 4'd2;
      load_ones <= 4'd4;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      d1        <= d1_nxt;
      reply     <= reply_nxt;
      pulse     <= pulse_nxt;
      load_tens <= tens_nxt;
      load_ones <= ones_nxt;
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: randomized and directed stimulus for uart_cmd_decoder,
// checked every cycle against a byte-stream command model.
module tb_uart_cmd_decoder;

  localparam int unsigned CLK_HZ     = 20_000;
  localparam int unsigned TIMEOUT_MS = 1;
  localparam int unsigned MAX_LOAD   = 24;
  localparam int          TO         = (CLK_HZ / 1000) * TIMEOUT_MS;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full;
  logic [7:0] w_data;
  logic       wr_uart;
  logic       cmd_reset, cmd_stop, cmd_play, cmd_load, err;
  logic [3:0] load_tens, load_ones;

  uart_cmd_decoder #(.CLK_HZ(CLK_HZ), .TIMEOUT_MS(TIMEOUT_MS), .MAX_LOAD(MAX_LOAD)) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart),
    .cmd_reset(cmd_reset), .cmd_stop(cmd_stop), .cmd_play(cmd_play), .cmd_load(cmd_load),
    .load_tens(load_tens), .load_ones(load_ones), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [4:0] v;
    logic [3:0] t;
    logic [3:0] o;
  } pev_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  pev_t       pq[$];
  logic [7:0] rq[$];
  bit         in_load = 0;
  int         ndig = 0, d0 = 0, lp = 0;
  logic [3:0] hold_t = 4'd2, hold_o = 4'd4;
  int         tx_mode = 0;

  int n_err = 0, n_nak = 0, n_ack = 0, n_load = 0, n_reset = 0, n_stop = 0, n_play = 0;
  int last_pop_cyc = 0, last_stop_cyc = 0, last_wr_cyc = 0, last_err_cyc = 0;
  logic [7:0] last_wr_data = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [4:0] v, input int c, input logic [7:0] rep,
                           input logic [3:0] t, input logic [3:0] o);
    pev_t e;
    e.c = c; e.v = v; e.t = t; e.o = o;
    pq.push_back(e);
    rq.push_back(rep);
  endtask

  // Command semantics of one consumed byte; effects appear the cycle after the pop.
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] ub;
    int d1, v;
    ub = b & 8'hDF;
    if (!in_load) begin
      if (ub == 8'h52)      expect_ev(5'b10000, cyc + 1, 8'h4B, 4'd0, 4'd0);
      else if (ub == 8'h53) expect_ev(5'b01000, cyc + 1, 8'h4B, 4'd0, 4'd0);
      else if (ub == 8'h50) expect_ev(5'b00100, cyc + 1, 8'h4B, 4'd0, 4'd0);
      else if (ub == 8'h4C) begin
        in_load = 1; ndig = 0; lp = cyc;
      end else if (b == 8'h0D || b == 8'h0A || b == 8'h20) begin
        in_load = 0;
      end else expect_ev(5'b00001, cyc + 1, 8'h3F, 4'd0, 4'd0);
    end else begin
      lp = cyc;
      if (b >= 8'h30 && b <= 8'h39) begin
        if (ndig == 0) begin
          d0 = int'(b) - 48; ndig = 1;
        end else begin
          d1 = int'(b) - 48;
          v  = d0 * 10 + d1;
          in_load = 0;
          if (v >= 1 && v <= int'(MAX_LOAD))
            expect_ev(5'b00010, cyc + 1, 8'h4B, 4'(d0), 4'(d1));
          else
            expect_ev(5'b00001, cyc + 1, 8'h3F, 4'd0, 4'd0);
        end
      end else begin
        in_load = 0;
        expect_ev(5'b00001, cyc + 1, 8'h3F, 4'd0, 4'd0);
      end
    end
  endtask

  task automatic drive_inputs();
    rx_empty = (rx_q.size() == 0);
    r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    case (tx_mode)
      1:       tx_full = ($urandom_range(0, 99) < 35);
      2:       tx_full = 1'b1;
      default: tx_full = 1'b0;
    endcase
  endtask

  // One clock: compare all outputs at the falling edge, then advance the FIFO model.
  task automatic tick();
    logic [4:0] pv, ev;
    bit do_pop;
    @(negedge clk);
    cyc++;
    if (in_load && !rst && cyc == lp + TO + 1) begin
      expect_ev(5'b00001, cyc, 8'h3F, 4'd0, 4'd0);
      in_load = 0;
    end
    chk("rd_uart", int'(rd_uart), int'(!rx_empty && rq.size() == 0 && !rst));
    chk("wr_uart", int'(wr_uart), int'(rq.size() > 0 && !tx_full));
    if (wr_uart) begin
      if (rq.size() > 0) begin
        chk("w_data", int'(w_data), int'(rq[0]));
        void'(rq.pop_front());
      end
      if (w_data == 8'h4B) n_ack++;
      if (w_data == 8'h3F) n_nak++;
      last_wr_cyc = cyc; last_wr_data = w_data;
    end
    pv = {cmd_reset, cmd_stop, cmd_play, cmd_load, err};
    ev = 5'b00000;
    if (pq.size() > 0 && pq[0].c == cyc) begin
      ev = pq[0].v;
      if (ev[1]) begin hold_t = pq[0].t; hold_o = pq[0].o; end
      void'(pq.pop_front());
    end
    chk("pulses", int'(pv), int'(ev));
    chk("load_tens", int'(load_tens), int'(hold_t));
    chk("load_ones", int'(load_ones), int'(hold_o));
    if (cmd_reset) n_reset++;
    if (cmd_stop) begin n_stop++; last_stop_cyc = cyc; end
    if (cmd_play) n_play++;
    if (cmd_load) n_load++;
    if (err) begin n_err++; last_err_cyc = cyc; end
    do_pop = rd_uart && (rx_q.size() > 0);
    if (do_pop) begin
      model_byte(rx_q[0]);
      last_pop_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (do_pop) void'(rx_q.pop_front());
    drive_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (rx_q.size() > 0 && k < 300) begin tick(); k++; end
    if (rx_q.size() > 0) begin
      chk("rx_drain_timeout", rx_q.size(), 0);
      rx_q.delete();
      drive_inputs();
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
    drive_inputs();
    drain();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    pq.delete(); rq.delete();
    in_load = 0; hold_t = 4'd2; hold_o = 4'd4;
    idle(n);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] rand_case(input logic [7:0] c);
    return ($urandom_range(0, 1) == 1) ? (c | 8'h20) : (c & 8'hDF);
  endfunction

  int s_err, s_nak, s_ack, s_load, s_reset, s_play, p1;
  logic [7:0] junk[8];

  initial begin
    rst = 1'b1; tx_mode = 0;
    drive_inputs();
    junk[0] = 8'h78; junk[1] = 8'h3F; junk[2] = 8'h00; junk[3] = 8'h41;
    junk[4] = 8'h0D; junk[5] = 8'h72; junk[6] = 8'h3A; junk[7] = 8'h2F;
    idle(3);
    chk("reset_tens", int'(load_tens), 2);
    chk("reset_ones", int'(load_ones), 4);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // 1: 's' -> stop pulse and 'K' both one cycle after the pop
    send(8'h73); p1 = last_pop_cyc;
    idle(3);
    chk("t1_stop_lat", last_stop_cyc - p1, 1);
    chk("t1_wr_lat", last_wr_cyc - p1, 1);
    chk("t1_wr_data", int'(last_wr_data), 8'h4B);

    // 2: "l14" then "L07"
    s_load = n_load; s_ack = n_ack;
    send(8'h6C); send(8'h31); send(8'h34); idle(3);
    chk("t2_tens14", int'(load_tens), 1);
    chk("t2_ones14", int'(load_ones), 4);
    chk("t2_load_cnt", n_load - s_load, 1);
    chk("t2_ack_cnt", n_ack - s_ack, 1);
    send(8'h4C); send(8'h30); send(8'h37); idle(3);
    chk("t2_tens07", int'(load_tens), 0);
    chk("t2_ones07", int'(load_ones), 7);

    // 3: out-of-range, zero and non-digit loads all NAK, regs unchanged
    do_reset(2);
    s_err = n_err; s_nak = n_nak; s_load = n_load;
    send(8'h6C); send(8'h32); send(8'h35); idle(3);
    send(8'h6C); send(8'h30); send(8'h30); idle(3);
    send(8'h6C); send(8'h78); idle(3);
    chk("t3_err_cnt", n_err - s_err, 3);
    chk("t3_nak_cnt", n_nak - s_nak, 3);
    chk("t3_load_cnt", n_load - s_load, 0);
    chk("t3_tens", int'(load_tens), 2);
    chk("t3_ones", int'(load_ones), 4);

    // 4: digit timeout, then 'p' is decoded normally
    s_err = n_err; s_nak = n_nak; s_play = n_play;
    send(8'h6C); send(8'h31); p1 = last_pop_cyc;
    idle(30);
    chk("t4_err_cnt", n_err - s_err, 1);
    chk("t4_nak_cnt", n_nak - s_nak, 1);
    chk("t4_timeout_lat", last_err_cyc - p1, 21);
    send(8'h70); idle(3);
    chk("t4_play_cnt", n_play - s_play, 1);

    // 5: TX full holds the reply and blocks the next pop
    s_reset = n_reset; s_play = n_play; s_ack = n_ack;
    tx_mode = 2;
    rx_q.push_back(8'h72); rx_q.push_back(8'h70);
    drive_inputs();
    idle(10);
    chk("t5_rx_left", rx_q.size(), 1);
    chk("t5_reset_cnt", n_reset - s_reset, 1);
    chk("t5_play_cnt", n_play - s_play, 0);
    chk("t5_ack_held", n_ack - s_ack, 0);
    tx_mode = 0;
    drive_inputs();
    drain(); idle(3);
    chk("t5_ack_cnt", n_ack - s_ack, 2);
    chk("t5_play_after", n_play - s_play, 1);

    // 6: reset between 'l' and '1' discards the load
    s_err = n_err; s_load = n_load;
    send(8'h6C);
    do_reset(2);
    send(8'h31); idle(3);
    chk("t6_err_cnt", n_err - s_err, 1);
    chk("t6_load_cnt", n_load - s_load, 0);
    s_ack = n_ack; s_nak = n_nak;
    send(8'h0D); send(8'h0A); send(8'h20); idle(3);
    chk("t6_no_reply", (n_ack - s_ack) + (n_nak - s_nak), 0);

    // randomized command stream with TX back-pressure and varied gaps
    tx_mode = 1;
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 7);
      if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 3));
      if (kind <= 2) begin
        case (kind)
          0:       send(rand_case(8'h72));
          1:       send(rand_case(8'h73));
          default: send(rand_case(8'h70));
        endcase
      end else if (kind <= 5) begin
        logic [7:0] seq[3];
        seq[0] = rand_case(8'h6C);
        seq[1] = 8'h30 + 8'($urandom_range(0, 3));
        seq[2] = 8'h30 + 8'($urandom_range(0, 9));
        if ($urandom_range(0, 7) == 0) seq[$urandom_range(1, 2)] = junk[$urandom_range(0, 7)];
        for (int j = 0; j < 3; j++) begin
          send(seq[j]);
          if ($urandom_range(0, 4) == 0) idle($urandom_range(15, 25));
          else idle($urandom_range(0, 3));
        end
      end else if (kind == 6) begin
        send(8'h0D);
      end else begin
        send(8'($urandom_range(0, 255)));
      end
      idle($urandom_range(0, 3));
    end

    tx_mode = 0;
    drive_inputs();
    idle(40);
    chk("end_pulses_pending", pq.size(), 0);
    chk("end_replies_pending", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
